// File: rtl/uart_echo_tester_if.sv
// Run-control and status bundle between a host controller and uart_echo_tester.
// The tester side uses the slave modport.
interface uart_echo_tester_if;
  logic        i_start;
  logic [7:0]  i_seed;
  logic [15:0] i_count;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic [15:0] o_err_count;
  logic [15:0] o_tx_count;
  logic [15:0] o_rx_count;

  modport slave (
    input  i_start, i_seed, i_count,
    output o_busy, o_done, o_pass, o_err_count, o_tx_count, o_rx_count
  );

  modport master (
    output i_start, i_seed, i_count,
    input  o_busy, o_done, o_pass, o_err_count, o_tx_count, o_rx_count
  );
endinterface

// File: rtl/uart_echo_tester.sv
// Far-end UART echo exerciser: sends seed+k byte sequences as 8N1 frames and
// checks each echoed frame, counting mismatches, framing errors and timeouts.
module uart_echo_tester #(
  parameter int TIMER_BITS      = 32,
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int TIMEOUT_BAUDS   = 20
) (
  input  logic              clk,
  input  logic              i_reset_n,
  output logic              o_txd,
  input  logic              i_rxd,
  uart_echo_tester_if.slave ctrl
);

  localparam logic [TIMER_BITS-1:0] BAUD_LAST    = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
  localparam logic [TIMER_BITS-1:0] HALF_LAST    = TIMER_BITS'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [TIMER_BITS-1:0] TIMEOUT_LAST = TIMER_BITS'(TIMEOUT_BAUDS * CLOCKS_PER_BAUD - 1);
  localparam logic [TIMER_BITS-1:0] TIMER_ONE    = TIMER_BITS'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_EMPTY, ST_SEND, ST_WAIT, ST_DONE} run_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  run_state_e            run_state, run_next;
  rx_state_e             rx_state, rx_next;
  logic [7:0]            seed_q;
  logic [15:0]           count_q, k_q;
  logic [3:0]            tx_bit_q;
  logic [TIMER_BITS-1:0] tx_timer_q, wait_timer_q, rx_timer_q;
  logic                  txd_q;
  logic [1:0]            rx_sync_q;
  logic                  rxd_prev_q;
  logic [2:0]            rx_bit_q;
  logic [7:0]            rx_shift_q;
  logic [15:0]           err_q, tx_cnt_q, rx_cnt_q;
  logic                  pass_hold_q;

  logic       rxd_s;
  logic [7:0] cur_byte;
  logic [9:0] tx_frame;
  logic       start_take, bit_end, frame_end, timeout_hit, last_byte, wait_exit;
  logic       rx_tick, rx_frame, rx_valid, rx_ferr, err_event;

  assign rxd_s       = rx_sync_q[1];
  assign cur_byte    = seed_q + k_q[7:0];
  assign tx_frame    = {1'b1, cur_byte, 1'b0};
  assign start_take  = (run_state == ST_IDLE) && ctrl.i_start;
  assign bit_end     = (tx_timer_q == BAUD_LAST);
  assign frame_end   = (run_state == ST_SEND) && bit_end && (tx_bit_q == 4'd9);
  assign timeout_hit = (run_state == ST_WAIT) && (wait_timer_q == TIMEOUT_LAST);
  assign last_byte   = ((k_q + 16'd1) == count_q);
  assign wait_exit   = (run_state == ST_WAIT) && (rx_frame || timeout_hit);
  // A completed frame takes priority over a coincident timeout; outside WAIT it is unsolicited.
  assign err_event   = rx_frame ? ((run_state != ST_WAIT) || rx_ferr || (rx_shift_q != cur_byte))
                                : timeout_hit;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_sync_q  <= 2'b11;
      rxd_prev_q <= 1'b1;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], i_rxd};
      rxd_prev_q <= rxd_s;
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) rx_state <= RX_IDLE;
    else            rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rxd_prev_q && !rxd_s) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bit_q == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_tick = 1'b0;
    case (rx_state)
      RX_START:         rx_tick = (rx_timer_q == HALF_LAST);
      RX_DATA, RX_STOP: rx_tick = (rx_timer_q == BAUD_LAST);
      default:          rx_tick = 1'b0;
    endcase
    rx_frame = (rx_state == RX_STOP) && rx_tick;
    rx_valid = rx_frame && rxd_s;
    rx_ferr  = rx_frame && !rxd_s;
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_timer_q <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      if ((rx_state == RX_IDLE) || rx_tick) rx_timer_q <= '0;
      else                                  rx_timer_q <= rx_timer_q + TIMER_ONE;
      if (rx_state == RX_START) begin
        rx_bit_q <= '0;
      end else if ((rx_state == RX_DATA) && rx_tick) begin
        rx_shift_q <= {rxd_s, rx_shift_q[7:1]};
        rx_bit_q   <= rx_bit_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) run_state <= ST_IDLE;
    else            run_state <= run_next;
  end

  // A zero-length run still passes through one busy cycle so done lands two cycles after start.
  always_comb begin
    run_next = run_state;
    case (run_state)
      ST_IDLE:  if (ctrl.i_start) run_next = (ctrl.i_count == 16'd0) ? ST_EMPTY : ST_SEND;
      ST_EMPTY: run_next = ST_DONE;
      ST_SEND:  if (frame_end) run_next = ST_WAIT;
      ST_WAIT:  if (wait_exit) run_next = last_byte ? ST_DONE : ST_SEND;
      ST_DONE:  run_next = ST_IDLE;
      default:  run_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_txd            = txd_q;
    ctrl.o_busy      = (run_state == ST_EMPTY) || (run_state == ST_SEND) || (run_state == ST_WAIT);
    ctrl.o_done      = (run_state == ST_DONE);
    ctrl.o_pass      = ((run_state == ST_DONE) || pass_hold_q) && (err_q == 16'd0);
    ctrl.o_err_count = err_q;
    ctrl.o_tx_count  = tx_cnt_q;
    ctrl.o_rx_count  = rx_cnt_q;
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seed_q       <= '0;
      count_q      <= '0;
      k_q          <= '0;
      tx_bit_q     <= '0;
      tx_timer_q   <= '0;
      wait_timer_q <= '0;
      txd_q        <= 1'b1;
      pass_hold_q  <= 1'b0;
    end else if (start_take) begin
      seed_q      <= ctrl.i_seed;
      count_q     <= ctrl.i_count;
      k_q         <= '0;
      tx_bit_q    <= '0;
      tx_timer_q  <= '0;
      txd_q       <= (ctrl.i_count == 16'd0);
      pass_hold_q <= 1'b0;
    end else begin
      case (run_state)
        ST_SEND: begin
          if (bit_end) begin
            tx_timer_q <= '0;
            if (tx_bit_q == 4'd9) begin
              tx_bit_q     <= '0;
              txd_q        <= 1'b1;
              wait_timer_q <= '0;
            end else begin
              tx_bit_q <= tx_bit_q + 4'd1;
              txd_q    <= tx_frame[tx_bit_q + 4'd1];
            end
          end else begin
            tx_timer_q <= tx_timer_q + TIMER_ONE;
          end
        end
        ST_WAIT: begin
          wait_timer_q <= wait_timer_q + TIMER_ONE;
          if (wait_exit) begin
            k_q <= k_q + 16'd1;
            if (!last_byte) begin
              tx_timer_q <= '0;
              tx_bit_q   <= '0;
              txd_q      <= 1'b0;
            end
          end
        end
        ST_DONE: pass_hold_q <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_q    <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else if (start_take) begin
      err_q    <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (frame_end && (tx_cnt_q != 16'hFFFF)) tx_cnt_q <= tx_cnt_q + 16'd1;
      if (rx_valid && (rx_cnt_q != 16'hFFFF))  rx_cnt_q <= rx_cnt_q + 16'd1;
      if (err_event && (err_q != 16'hFFFF))    err_q    <= err_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Scoreboard bench for uart_echo_tester: an echo model loops o_txd back to i_rxd
// with optional corruption, and run results are checked against a per-run model.
module tb_uart_echo_tester;

  localparam int CPB      = 16;
  localparam int TO_BAUDS = 20;

  typedef struct {
    logic [7:0] val;
    logic       stop;
    logic       glitch;
  } echo_t;

  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic [15:0] tx;
    logic [15:0] rx;
  } result_t;

  logic clk = 1'b0;
  logic rst_n;
  logic txd;
  logic rxd;

  int checks   = 0;
  int failures = 0;
  int epoch    = 0;

  bit echo_en     = 1'b0;
  int corrupt_idx = -1;
  int ferr_idx    = -1;
  int tx_idx      = 0;

  logic [7:0] exp_tx_q[$];
  echo_t      echo_q[$];
  result_t    run_q[$];

  uart_echo_tester_if ctrl_if();

  uart_echo_tester #(
    .TIMER_BITS     (16),
    .CLOCKS_PER_BAUD(CPB),
    .TIMEOUT_BAUDS  (TO_BAUDS)
  ) dut (
    .clk      (clk),
    .i_reset_n(rst_n),
    .o_txd    (txd),
    .i_rxd    (rxd),
    .ctrl     (ctrl_if)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%b required=%b", name, actual, expected);
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Reference: every byte either echoes back intact, corrupted, with a bad stop bit, or never.
  function automatic result_t model_run(input logic [7:0] seed, input int count, input bit echo,
                                        input int cidx, input int fidx);
    result_t    r;
    int         err = 0;
    int         rx  = 0;
    logic [7:0] b;
    logic [7:0] ev;
    for (int k = 0; k < count; k++) begin
      b = seed + 8'(k);
      if (!echo) begin
        err++;
      end else if (k == fidx) begin
        err++;
      end else begin
        rx++;
        ev = (k == cidx) ? 8'h00 : b;
        if (ev != b) err++;
      end
    end
    r.pass = (err == 0);
    r.err  = 16'(err);
    r.tx   = 16'(count);
    r.rx   = 16'(rx);
    return r;
  endfunction

  task automatic handle_tx_frame(input logic [7:0] data, input logic stop);
    logic [7:0] exp_b;
    echo_t      e;
    check_bit("tx_stop_bit", stop, 1'b1);
    check_bit("tx_frame_expected", exp_tx_q.size() != 0, 1'b1);
    if (exp_tx_q.size() != 0) begin
      exp_b = exp_tx_q.pop_front();
      check_val("tx_byte", {8'h00, data}, {8'h00, exp_b});
    end
    if (echo_en) begin
      e.val    = (tx_idx == corrupt_idx) ? 8'h00 : data;
      e.stop   = (tx_idx != ferr_idx);
      e.glitch = 1'b0;
      echo_q.push_back(e);
    end
    tx_idx++;
  endtask

  initial begin : tx_monitor
    logic       prev;
    logic [7:0] data;
    logic       stop;
    int         my_epoch;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if ((prev === 1'b1) && (txd === 1'b0) && (rst_n === 1'b1)) begin
        my_epoch = epoch;
        repeat (CPB / 2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          data[b] = txd;
        end
        repeat (CPB) @(negedge clk);
        stop = txd;
        if (my_epoch == epoch) handle_tx_frame(data, stop);
      end
      prev = txd;
    end
  end

  task automatic send_frame(input logic [7:0] val, input logic stop, input int ep);
    logic [9:0] bits;
    bits = {stop, val, 1'b0};
    for (int b = 0; b < 10; b++) begin
      if (ep != epoch) break;
      rxd = bits[b];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  initial begin : echo_sender
    echo_t e;
    rxd = 1'b1;
    forever begin
      @(negedge clk);
      if (echo_q.size() != 0) begin
        e = echo_q.pop_front();
        if (e.glitch) begin
          rxd = 1'b0;
          repeat (CPB / 4) @(negedge clk);
          rxd = 1'b1;
        end else begin
          send_frame(e.val, e.stop, epoch);
        end
      end
    end
  end

  initial begin : done_monitor
    result_t exp;
    forever begin
      @(negedge clk);
      if ((rst_n === 1'b1) && (ctrl_if.o_done === 1'b1)) begin
        check_bit("done_expected", run_q.size() != 0, 1'b1);
        if (run_q.size() != 0) begin
          exp = run_q.pop_front();
          check_bit("done_busy_low", ctrl_if.o_busy, 1'b0);
          check_bit("done_pass", ctrl_if.o_pass, exp.pass);
          check_val("done_err_count", ctrl_if.o_err_count, exp.err);
          check_val("done_tx_count", ctrl_if.o_tx_count, exp.tx);
          check_val("done_rx_count", ctrl_if.o_rx_count, exp.rx);
        end
      end
    end
  end

  task automatic start_run(input logic [7:0] seed, input int count, input bit echo,
                           input int cidx, input int fidx);
    echo_en     = echo;
    corrupt_idx = cidx;
    ferr_idx    = fidx;
    tx_idx      = 0;
    for (int k = 0; k < count; k++) exp_tx_q.push_back(seed + 8'(k));
    run_q.push_back(model_run(seed, count, echo, cidx, fidx));
    @(negedge clk);
    ctrl_if.i_start = 1'b1;
    ctrl_if.i_seed  = seed;
    ctrl_if.i_count = 16'(count);
    @(negedge clk);
    ctrl_if.i_start = 1'b0;
    check_bit("busy_at_cycle1", ctrl_if.o_busy, 1'b1);
    check_bit("txd_at_cycle1", txd, count == 0);
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit low_seen);
    cyc      = 1;
    low_seen = (txd !== 1'b1);
    while ((ctrl_if.o_done !== 1'b1) && (cyc < budget)) begin
      @(negedge clk);
      cyc++;
      if (txd !== 1'b1) low_seen = 1'b1;
    end
    check_bit("done_within_budget", ctrl_if.o_done === 1'b1, 1'b1);
  endtask

  task automatic apply_stimulus(input logic [7:0] seed, input int count, input bit echo,
                                input int cidx, input int fidx, output int cyc, output bit low_seen);
    start_run(seed, count, echo, cidx, fidx);
    wait_done(8000, cyc, low_seen);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_bit({tag, "_txd"}, txd, 1'b1);
    check_bit({tag, "_busy"}, ctrl_if.o_busy, 1'b0);
    check_bit({tag, "_done"}, ctrl_if.o_done, 1'b0);
    check_bit({tag, "_pass"}, ctrl_if.o_pass, 1'b0);
    check_val({tag, "_err"}, ctrl_if.o_err_count, 16'd0);
    check_val({tag, "_tx"}, ctrl_if.o_tx_count, 16'd0);
    check_val({tag, "_rx"}, ctrl_if.o_rx_count, 16'd0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int         cyc;
    bit         low_seen;
    int         budget;
    echo_t      e;
    logic [7:0] r_seed;
    int         r_count, r_cidx, r_fidx;
    bit         r_echo;

    rst_n           = 1'b0;
    ctrl_if.i_start = 1'b0;
    ctrl_if.i_seed  = 8'h00;
    ctrl_if.i_count = 16'd0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] clean loopback seed 0x41 count 4");
    apply_stimulus(8'h41, 4, 1'b1, -1, -1, cyc, low_seen);

    $display("[TB] wrapping bytes with corrupted second echo");
    apply_stimulus(8'hFE, 3, 1'b1, 1, -1, cyc, low_seen);

    $display("[TB] no echo, timeouts only");
    apply_stimulus(8'h20, 2, 1'b0, -1, -1, cyc, low_seen);
    check_bit("timeout_done_window", (cyc >= 955) && (cyc <= 965), 1'b1);

    $display("[TB] framing error, then unsolicited byte and glitch in idle");
    apply_stimulus(8'h33, 2, 1'b1, -1, 0, cyc, low_seen);
    e.val = 8'h5A; e.stop = 1'b1; e.glitch = 1'b0;
    echo_q.push_back(e);
    repeat (12 * CPB) @(negedge clk);
    check_val("unsolicited_err", ctrl_if.o_err_count, 16'd2);
    check_val("unsolicited_rx", ctrl_if.o_rx_count, 16'd2);
    check_bit("unsolicited_idle", ctrl_if.o_busy, 1'b0);
    e.glitch = 1'b1;
    echo_q.push_back(e);
    repeat (12 * CPB) @(negedge clk);
    check_val("glitch_err", ctrl_if.o_err_count, 16'd2);
    check_val("glitch_rx", ctrl_if.o_rx_count, 16'd2);

    $display("[TB] asynchronous reset in the middle of frame 2");
    start_run(8'h10, 3, 1'b1, -1, -1);
    budget = 0;
    while ((tx_idx < 1) && (budget < 2000)) begin
      @(negedge clk);
      budget++;
    end
    check_bit("reset_test_frame1_seen", tx_idx >= 1, 1'b1);
    budget = 0;
    while ((txd !== 1'b0) && (budget < 2000)) begin
      @(negedge clk);
      budget++;
    end
    check_bit("reset_test_frame2_started", txd === 1'b0, 1'b1);
    repeat (3 * CPB) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrun_reset");
    epoch++;
    exp_tx_q.delete();
    run_q.delete();
    echo_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);

    $display("[TB] clean run after reset with start pulses while busy");
    fork
      begin
        start_run(8'h70, 2, 1'b1, -1, -1);
        wait_done(8000, cyc, low_seen);
      end
      begin
        repeat (60) @(negedge clk);
        ctrl_if.i_start = 1'b1;
        ctrl_if.i_seed  = 8'h99;
        ctrl_if.i_count = 16'd7;
        @(negedge clk);
        ctrl_if.i_start = 1'b0;
        repeat (300) @(negedge clk);
        ctrl_if.i_start = 1'b1;
        @(negedge clk);
        ctrl_if.i_start = 1'b0;
      end
    join
    repeat (20) @(negedge clk);

    $display("[TB] zero-length run");
    apply_stimulus(8'h00, 0, 1'b1, -1, -1, cyc, low_seen);
    check_val("count0_done_cycle", 16'(cyc), 16'd2);
    check_bit("count0_txd_toggled", low_seen, 1'b0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      r_seed  = 8'($urandom);
      r_count = $urandom_range(1, 5);
      r_echo  = ($urandom_range(0, 3) != 0);
      r_cidx  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, r_count - 1) : -1;
      r_fidx  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, r_count - 1) : -1;
      apply_stimulus(r_seed, r_count, r_echo, r_cidx, r_fidx, cyc, low_seen);
    end

    check_bit("all_tx_bytes_seen", exp_tx_q.size() == 0, 1'b1);
    check_bit("all_runs_done", run_q.size() == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
